// File: rtl/sm3_compression.sv
`default_nettype none
// ============================================================================
// Module   : sm3_compression
// Purpose  : SM3 64-round compression, four rounds per clock, with IV/V chaining
// Revision : 1.0
// ============================================================================
module sm3_compression #(
    parameter logic [255:0] IV   = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e,
    parameter logic [31:0]  T_LO = 32'h79cc4519,
    parameter logic [31:0]  T_HI = 32'h7a879d8a
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         first_blk,
    input  logic [6:0]   s,
    input  logic [31:0]  WJ_0,
    input  logic [31:0]  WJ_1,
    input  logic [31:0]  WJ_2,
    input  logic [31:0]  WJ_3,
    input  logic [31:0]  fj_0,
    input  logic [31:0]  fj_1,
    input  logic [31:0]  fj_2,
    input  logic [31:0]  fj_3,
    output logic [255:0] hash,
    output logic         done,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [6:0]   r_rnd_cnt;
    logic [255:0] r_work;
    logic [255:0] r_v;
    logic [255:0] r_hash;
    logic         r_done;
    logic         w_load;
    logic         w_advance;
    logic         w_complete;
    logic         w_abort;
    logic [31:0]  w_wj [0:3];
    logic [31:0]  w_wp [0:3];
    logic [255:0] w_chain [0:4];

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [255:0] sm3_round(input logic [255:0] st, input logic [6:0] j,
                                               input logic [31:0] w, input logic [31:0] wp);
        logic [31:0] a, b, c, d, e, f, g, h;
        logic [31:0] tj, a12, ss1, ss2, ff, gg, tt1, tt2;
        {a, b, c, d, e, f, g, h} = st;
        tj  = (j < 7'd16) ? T_LO : T_HI;
        a12 = rotl(a, 5'd12);
        ss1 = rotl(a12 + e + rotl(tj, j[4:0]), 5'd7);
        ss2 = ss1 ^ a12;
        ff  = (j < 7'd16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
        gg  = (j < 7'd16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
        tt1 = ff + d + ss2 + wp;
        tt2 = gg + h + ss1 + w;
        return {tt1, a, rotl(b, 5'd9), c, tt2 ^ rotl(tt2, 5'd9) ^ rotl(tt2, 5'd17), e, rotl(f, 5'd19), g};
    endfunction

    assign w_wj[0] = WJ_0;
    assign w_wj[1] = WJ_1;
    assign w_wj[2] = WJ_2;
    assign w_wj[3] = WJ_3;
    assign w_wp[0] = fj_0;
    assign w_wp[1] = fj_1;
    assign w_wp[2] = fj_2;
    assign w_wp[3] = fj_3;
    assign w_chain[0] = r_work;

    // Four rounds chained combinationally; round index is rnd_cnt+k (equals s when advancing)
    generate
        for (genvar k = 0; k < 4; k++) begin : g_round
            assign w_chain[k+1] = sm3_round(w_chain[k], r_rnd_cnt + 7'(k), w_wj[k], w_wp[k]);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_next = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_rnd_cnt == 7'd64) begin
                    w_state_next = ST_FINAL;
                end else if (s == r_rnd_cnt) begin
                    w_advance = 1'b1;
                    // Leave RUN on the last group so done lands on the s==65 edge
                    if (r_rnd_cnt == 7'd60) w_state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (!en) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (s == 7'd65) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rnd_cnt <= 7'd0;
            r_work    <= 256'd0;
            r_v       <= IV;
            r_hash    <= 256'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_load) begin
                r_work    <= first_blk ? IV : r_v;
                r_rnd_cnt <= 7'd0;
                if (first_blk) r_v <= IV;
            end
            if (w_advance) begin
                r_work    <= w_chain[4];
                r_rnd_cnt <= r_rnd_cnt + 7'd4;
            end
            if (w_complete) begin
                r_v    <= r_v ^ r_work;
                r_hash <= r_v ^ r_work;
            end
            if (w_abort) r_rnd_cnt <= 7'd0;
        end
    end

    assign hash = r_hash;
    assign done = r_done;
    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sm3_compression.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm3_compression
// Purpose  : Self-checking bench for sm3_compression against an SM3 reference model
// Revision : 1.0
// ============================================================================
module tb_sm3_compression;

    localparam logic [255:0] IV  = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
    localparam logic [255:0] ABC_DIGEST  = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
    localparam logic [255:0] ABCD_DIGEST = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ABCD_BLK1 = {16{32'h61626364}};
    localparam logic [511:0] ABCD_BLK2 = {32'h80000000, 448'h0, 32'h00000200};

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         first_blk;
    logic [6:0]   s;
    logic [31:0]  WJ_0, WJ_1, WJ_2, WJ_3;
    logic [31:0]  fj_0, fj_1, fj_2, fj_3;
    logic [255:0] hash;
    logic         done;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [31:0]  ew  [0:67];
    logic [31:0]  ewp [0:63];
    logic [255:0] vmodel;
    logic [255:0] hmodel;

    sm3_compression dut (
        .clk(clk), .rst(rst), .en(en), .first_blk(first_blk), .s(s),
        .WJ_0(WJ_0), .WJ_1(WJ_1), .WJ_2(WJ_2), .WJ_3(WJ_3),
        .fj_0(fj_0), .fj_1(fj_1), .fj_2(fj_2), .fj_3(fj_3),
        .hash(hash), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic void expand(input logic [511:0] blk);
        logic [31:0] x;
        for (int i = 0; i < 16; i++) ew[i] = blk[511 - 32*i -: 32];
        for (int j = 16; j < 68; j++) begin
            x = ew[j-16] ^ ew[j-9] ^ rl(ew[j-3], 15);
            ew[j] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(ew[j-13], 7) ^ ew[j-6];
        end
        for (int j = 0; j < 64; j++) ewp[j] = ew[j] ^ ew[j+4];
    endfunction

    // Standard SM3 compression function CF(V, B)
    function automatic logic [255:0] ref_compress(input logic [255:0] v, input logic [511:0] blk);
        logic [31:0] a, b, c, d, e, f, g, h, t, ss1, ss2, ff, gg, tt1, tt2;
        expand(blk);
        {a, b, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rl(rl(a, 12) + e + rl(t, j), 7);
            ss2 = ss1 ^ rl(a, 12);
            ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
            gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ff + d + ss2 + ewp[j];
            tt2 = gg + h + ss1 + ew[j];
            d = c; c = rl(b, 9); b = a; a = tt1;
            h = g; g = rl(f, 19); f = e; e = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
        end
        return v ^ {a, b, c, d, e, f, g, h};
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_words(input int j);
        s = 7'(j);
        WJ_0 = ew[j];   WJ_1 = ew[j+1];   WJ_2 = ew[j+2];   WJ_3 = ew[j+3];
        fj_0 = ewp[j];  fj_1 = ewp[j+1];  fj_2 = ewp[j+2];  fj_3 = ewp[j+3];
    endtask

    // Mimics the expansion stage: s=0 one edge after en, then 4,8,..60, then 65.
    // abort_edge = edge number (counted from en) at which en is sampled low; 0 = none.
    task automatic run_block(input logic [511:0] blk, input bit first, input int stall_grp,
                             input int abort_edge, input bit keep_en);
        logic [255:0] exp;
        int done_seen;
        done_seen = 0;
        exp = ref_compress(first ? IV : vmodel, blk);
        en = 1'b1; first_blk = first; s = 7'd64;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL start: busy=%b done=%b want busy=1 done=0", busy, done);
        end
        for (int g = 0; g < 16; g++) begin
            if (g + 2 == abort_edge) begin
                en = 1'b0;
                @(posedge clk); #1;
                total++;
                if (busy !== 1'b0 || done !== 1'b0 || hash !== hmodel) begin
                    bad++; $display("FAIL abort_run: busy=%b done=%b hash=%h want 0 0 %h", busy, done, hash, hmodel);
                end
                s = 7'd64;
                return;
            end
            drive_words(4*g);
            @(posedge clk); #1;
            if (done) done_seen++;
            if (g == stall_grp) begin
                repeat (5) begin
                    @(posedge clk); #1;
                    if (done || !busy) done_seen++;
                end
            end
        end
        total++;
        if (done_seen != 0) begin
            bad++; $display("FAIL early_done: got %0d stray cycles want 0", done_seen);
        end
        s = 7'd65;
        if (abort_edge == 18) en = 1'b0;
        @(posedge clk); #1;
        if (abort_edge == 18) begin
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || hash !== hmodel) begin
                bad++; $display("FAIL abort_final: busy=%b done=%b hash=%h want 0 0 %h", busy, done, hash, hmodel);
            end
            s = 7'd64;
            return;
        end
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL done_pulse: got %b want 1", done);
        end
        total++;
        if (hash !== exp) begin
            bad++; $display("FAIL digest: got %h want %h", hash, exp);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL busy_end: got %b want 0", busy);
        end
        vmodel = exp;
        hmodel = exp;
        s = 7'd64;
        if (!keep_en) begin
            en = 1'b0;
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0) begin
                bad++; $display("FAIL done_width: got %b want 0", done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; first_blk = 1'b0; s = 7'd64;
        WJ_0 = 0; WJ_1 = 0; WJ_2 = 0; WJ_3 = 0; fj_0 = 0; fj_1 = 0; fj_2 = 0; fj_3 = 0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (hash !== 256'd0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_state: hash=%h done=%b busy=%b want 0", hash, done, busy);
        end
        #2 rst = 1'b1;
        vmodel = IV; hmodel = 256'd0;
        @(posedge clk); #1;
        total++;
        if (hash !== 256'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_release: hash=%h busy=%b want 0", hash, busy);
        end
        // V must come out of reset as IV: chain with first_blk=0
        run_block(rand_blk(), 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_abc();
        run_block(ABC_BLK, 1'b1, -1, 0, 1'b0);
        total++;
        if (hash !== ABC_DIGEST) begin
            bad++; $display("FAIL abc_vector: got %h want %h", hash, ABC_DIGEST);
        end
    endtask

    task automatic test_two_block();
        run_block(ABCD_BLK1, 1'b1, -1, 0, 1'b0);
        run_block(ABCD_BLK2, 1'b0, -1, 0, 1'b0);
        total++;
        if (hash !== ABCD_DIGEST) begin
            bad++; $display("FAIL abcd_vector: got %h want %h", hash, ABCD_DIGEST);
        end
    endtask

    task automatic test_abort();
        run_block(rand_blk(), 1'b1, -1, 0, 1'b0);
        run_block(rand_blk(), 1'b0, -1, 10, 1'b0);
        @(posedge clk); #1;
        run_block(rand_blk(), 1'b0, -1, 0, 1'b0);
        run_block(rand_blk(), 1'b0, -1, 18, 1'b0);
        @(posedge clk); #1;
        run_block(rand_blk(), 1'b0, -1, 0, 1'b0);
        test_abc();
    endtask

    task automatic test_stall();
        run_block(ABC_BLK, 1'b1, 2, 0, 1'b0);
        total++;
        if (hash !== ABC_DIGEST) begin
            bad++; $display("FAIL stall_vector: got %h want %h", hash, ABC_DIGEST);
        end
    endtask

    task automatic test_async_reset();
        expand(ABC_BLK);
        en = 1'b1; first_blk = 1'b1; s = 7'd64;
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) begin
            drive_words(4*g);
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hash !== 256'd0) begin
            bad++; $display("FAIL async_reset: busy=%b done=%b hash=%h want 0", busy, done, hash);
        end
        en = 1'b0; s = 7'd64;
        vmodel = IV; hmodel = 256'd0;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        test_abc();
    endtask

    task automatic test_back_to_back();
        run_block(rand_blk(), 1'b1, -1, 0, 1'b1);
        run_block(rand_blk(), 1'b0, -1, 0, 1'b1);
        run_block(ABC_BLK, 1'b1, -1, 0, 1'b0);
        total++;
        if (hash !== ABC_DIGEST) begin
            bad++; $display("FAIL b2b_vector: got %h want %h", hash, ABC_DIGEST);
        end
    endtask

    task automatic test_random_chain();
        for (int i = 0; i < 4; i++)
            run_block(rand_blk(), (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                      (i == 2) ? int'($urandom_range(0, 15)) : -1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_abort();
        test_stall();
        test_async_reset();
        test_back_to_back();
        test_random_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
